// File: rtl/rr_arb_pkg.sv
// Shared types for the 2-request round-robin arbiter and its request queues.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rr_arb_pkg;

    localparam int N_REQ = 2;

    typedef logic [N_REQ-1:0]         req_vec_t;
    typedef logic [$clog2(N_REQ)-1:0] ch_id_t;

    // Per-channel wait counter step: clears on pop, otherwise counts waiting
    // cycles and saturates at all-ones.
    function automatic logic [15:0] wait_cnt_next(input logic [15:0] cur,
                                                  input logic        req,
                                                  input logic        pop);
        if (pop) begin
            return 16'd0;
        end else if (req && (cur != 16'hFFFF)) begin
            return cur + 16'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/rr_arb_queue_fifo.sv
// Per-channel request FIFO: DEPTH entries of WIDTH bits, head shown combinationally.
// Latency: a pushed word is visible at head_o/count_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; full_o is state-only.
//
// Ports: clk, rst (async active-low); push_i/push_data_i write side;
//        pop_i read side; head_o oldest word; count_o occupancy; full_o/empty_o.
module rr_arb_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             push_acc, pop_acc;

    assign full_o   = (count_q == CW'(DEPTH));
    assign empty_o  = (count_q == '0);
    assign count_o  = count_q;
    assign head_o   = mem_q[rd_ptr_q];

    // Full is judged on registered state, so a push at full is refused even
    // when the same edge frees a slot.
    assign push_acc = push_i & ~full_o;
    assign pop_acc  = pop_i & ~empty_o;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once count says they are valid.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/rr_arb_request_queues.sv
// Queues two valid/ready streams, raises per-channel requests to the arbiter and forwards granted words.
// Latency: 1 cycle from grant to out_valid; a pushed word can be requested the cycle after its push.
// Backpressure: in*_ready drops at FIFO full; requests drop while the output register is held by !out_ready.
//
// Ports: clk, rst (async active-low); in0_*/in1_* push streams; requests -> arbiter,
//        grants <- arbiter (same cycle); out_valid/out_data/out_id/out_ready output stream.
//        With RR_ARB_REQUEST_QUEUES_WAIT_STATS_EN defined: wait_cnt0/wait_cnt1 fairness counters.
module rr_arb_request_queues
    import rr_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output req_vec_t         requests,
    input  req_vec_t         grants,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output ch_id_t           out_id,
    input  logic             out_ready
`ifdef RR_ARB_REQUEST_QUEUES_WAIT_STATS_EN
    ,
    output logic [15:0]      wait_cnt0,
    output logic [15:0]      wait_cnt1
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] head0, head1;
    logic [CW-1:0]    count0, count1;
    logic             full0, full1, empty0, empty1;
    logic             slot_free;
    logic             pop0, pop1;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    ch_id_t           out_id_q,    out_id_d;

    rr_arb_queue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in0_valid),
        .push_data_i (in0_data),
        .pop_i       (pop0 & ~empty0),
        .head_o      (head0),
        .count_o     (count0),
        .full_o      (full0),
        .empty_o     (empty0)
    );

    rr_arb_queue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk         (clk),
        .rst         (rst),
        .push_i      (in1_valid),
        .push_data_i (in1_data),
        .pop_i       (pop1 & ~empty1),
        .head_o      (head1),
        .count_o     (count1),
        .full_o      (full1),
        .empty_o     (empty1)
    );

    assign in0_ready = ~full0;
    assign in1_ready = ~full1;

    // Requests depend only on registered state and out_ready, never on grants,
    // so the arbiter's combinational grant path cannot form a loop.
    assign slot_free = ~out_valid_q | out_ready;
    assign requests  = {(count1 != '0) & slot_free, (count0 != '0) & slot_free};

    // Grants without a matching request are ignored; a double grant is
    // resolved in favour of channel 0 so at most one word moves per cycle.
    assign pop0 = grants[0] & requests[0];
    assign pop1 = grants[1] & requests[1] & ~pop0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (pop0) begin
            out_valid_d = 1'b1;
            out_data_d  = head0;
            out_id_d    = ch_id_t'(0);
        end else if (pop1) begin
            out_valid_d = 1'b1;
            out_data_d  = head1;
            out_id_d    = ch_id_t'(1);
        end else if (out_ready) begin
            // Word drained with nothing behind it; data/id keep their last value.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

`ifdef RR_ARB_REQUEST_QUEUES_WAIT_STATS_EN
    logic [15:0] wait0_q, wait0_d;
    logic [15:0] wait1_q, wait1_d;

    always_comb begin
        wait0_d = wait_cnt_next(wait0_q, requests[0], pop0);
        wait1_d = wait_cnt_next(wait1_q, requests[1], pop1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait0_q <= '0;
            wait1_q <= '0;
        end else begin
            wait0_q <= wait0_d;
            wait1_q <= wait1_d;
        end
    end

    assign wait_cnt0 = wait0_q;
    assign wait_cnt1 = wait1_q;
`endif

endmodule

// File: doc/rr_arb_request_queues.md
Name: rr_arb_request_queues

Overview:
- Upstream companion of the 2-request round-robin arbiter. It buffers two independent valid/ready input streams in per-channel FIFOs and presents non-empty status as `requests[1:0]`.
- It consumes the arbiter's `grants[1:0]`, pops the granted FIFO and drives a single registered output stream tagged with the source channel id.
- Arbitration policy lives entirely in the arbiter. This block only queues, requests and forwards.

Parameters:
- WIDTH, 8, payload width of each channel.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- in0_valid  input  1  channel 0 push request.
- in0_data  input  WIDTH  channel 0 payload.
- in0_ready  output  1  channel 0 FIFO not full.
- in1_valid  input  1  channel 1 push request.
- in1_data  input  WIDTH  channel 1 payload.
- in1_ready  output  1  channel 1 FIFO not full.
- requests  output  2  to arbiter; bit i = FIFO i non-empty AND output slot can accept.
- grants  input  2  from arbiter; combinational response to `requests` in the same cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  granted payload.
- out_id  output  1  source channel of `out_data`.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (rst low, asynchronous):
  - Both FIFOs empty; pointers and counts cleared.
  - out_valid=0, out_data=0, out_id=0.
  - requests=2'b00; in0_ready=in1_ready=1 once reset is released.
  - Reset mid-operation discards all queued and output data with no drain.
- FIFO i:
  - Push when ini_valid & ini_ready at posedge.
  - ini_ready = count_i != DEPTH. It is combinational from state only and never depends on the same-cycle pop.
  - Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- slot_free = !out_valid | out_ready.
- requests[i] = (count_i != 0) & slot_free. Combinational; no dependence on grants (no combinational loop).
- Effective pop:
  - pop_i = grants[i] & requests[i].
  - A grant bit with its request low is ignored.
  - If both grants are high (arbiter protocol violation), only channel 0 pops.
- On pop of channel i at posedge:
  - out_data <= FIFO i head, out_id <= i, out_valid <= 1.
  - Latency from grant to output is 1 cycle.
- No pop and out_ready & out_valid: out_valid <= 0; out_data and out_id hold.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
  - At count==DEPTH the push is refused (ready low) even if a pop occurs that cycle.
  - At count==0 the pushed word is not visible to requests until the next cycle (no bypass).
- Throughput:
  - 1 word/cycle while out_ready=1.
  - Output holds stable while out_valid & !out_ready.
- Ordering: FIFO order within a channel is preserved; no ordering guarantee across channels.

Optional Feature:
- Macro: RR_ARB_REQUEST_QUEUES_WAIT_STATS_EN.
- With the macro, adds outputs wait_cnt0 and wait_cnt1 (16 bits each, saturating at 16'hFFFF):
  - wait_cnti increments each cycle requests[i]=1 and pop_i=0.
  - It clears to 0 on pop_i and on reset.
  - Used to check round-robin fairness: with a fair arbiter and both channels backlogged, no counter exceeds 1.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package rr_arb_pkg:
  - localparam N_REQ = 2.
  - Typedef req_vec_t = logic [N_REQ-1:0], shared with the arbiter.
  - Typedef ch_id_t = logic [$clog2(N_REQ)-1:0].
- One natural sub-module, rr_arb_queue_fifo (WIDTH, DEPTH; push/pop, head, count, full/empty), instantiated twice.
- Output register and request/pop logic stay in the top.

Test Plan:
- Reset release, no traffic -> requests=00, out_valid=0, in0_ready=in1_ready=1 for 10 cycles.
- Push 8'hA1 on ch0 only; grants mirror requests (grants=01 when requests=01); out_ready=1 -> requests=01 one cycle after push; out_valid=1, out_data=A1, out_id=0 one cycle after the grant.
- Fill ch1 with 10,11,12,13 (DEPTH=4), grants held 00 -> in1_ready=0 after 4th push, 5th push (14) refused; then grant ch1 4 cycles -> outputs 10,11,12,13, id=1, in order.
- Both FIFOs loaded (ch0: 01,02; ch1: 81,82), arbiter alternates grants 01,10,01,10 -> out_data 01,81,02,82 with ids 0,1,0,1.
- out_ready=0 while out_valid=1 and ch0 non-empty -> requests=00, output stable; raise out_ready -> requests=01 the same cycle, next word 1 cycle after grant.
- Protocol errors: grants=11 with both queues holding data -> only ch0 pops; grants=10 with ch1 empty -> no pop, out_valid unchanged; assert rst low mid-stream -> out_valid=0 immediately, queues empty after release.
